// File: rtl/wallace_mul16_seq.sv
// 16x16 unsigned multiply sequencer. It reuses one external combinational 8x8
// multiplier over four byte partial products and accumulates them into a 32-bit product.
module wallace_mul16_seq #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PP0,
    S_PP1,
    S_PP2,
    S_PP3,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [4:0]  weight;
  logic [3:0]  remain;
  logic [3:0]  start_mask;
  logic        accept;

  // Bit i is set when partial product PPi has to run for this operand pair.
  function automatic logic [3:0] pp_mask(input logic [15:0] a, input logic [15:0] b);
    logic a_lo;
    logic a_hi;
    logic b_lo;
    logic b_hi;
    a_lo = |a[7:0];
    a_hi = |a[15:8];
    b_lo = |b[7:0];
    b_hi = |b[15:8];
    if (!SKIP_ZERO) return 4'hF;
    return {a_hi & b_hi, a_lo & b_hi, a_hi & b_lo, a_lo & b_lo};
  endfunction

  function automatic state_t first_active(input logic [3:0] mask);
    if (mask[0]) return S_PP0;
    if (mask[1]) return S_PP1;
    if (mask[2]) return S_PP2;
    if (mask[3]) return S_PP3;
    return S_DONE;
  endfunction

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    mul_a  = 8'h00;
    mul_b  = 8'h00;
    weight = 5'd0;
    remain = 4'b0000;
    case (state)
      S_PP0: begin
        mul_a  = a_q[7:0];
        mul_b  = b_q[7:0];
        weight = 5'd0;
        remain = 4'b1110;
      end
      S_PP1: begin
        mul_a  = a_q[15:8];
        mul_b  = b_q[7:0];
        weight = 5'd8;
        remain = 4'b1100;
      end
      S_PP2: begin
        mul_a  = a_q[7:0];
        mul_b  = b_q[15:8];
        weight = 5'd8;
        remain = 4'b1000;
      end
      S_PP3: begin
        mul_a  = a_q[15:8];
        mul_b  = b_q[15:8];
        weight = 5'd16;
        remain = 4'b0000;
      end
      default: ;
    endcase
  end

  assign acc_next   = acc + ({16'h0000, mul_p} << weight);
  assign start_mask = pp_mask(op_a, op_b);
  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy       = (state == S_PP0) || (state == S_PP1) || (state == S_PP2) || (state == S_PP3);
  assign done       = (state == S_DONE);

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = first_active(start_mask);
    end else begin
      case (state)
        S_IDLE, S_DONE: state_next = S_IDLE;
        default:        state_next = first_active(pp_mask(a_q, b_q) & remain);
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      acc    <= 32'h0000_0000;
      result <= 32'h0000_0000;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q <= op_a;
        b_q <= op_b;
        acc <= 32'h0000_0000;
      end else if (busy) begin
        acc <= acc_next;
      end
      // Going straight from accept to DONE means no partial product is nonzero.
      if (state_next == S_DONE) begin
        result <= accept ? 32'h0000_0000 : acc_next;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mul16_seq.sv
// Self-checking bench for wallace_mul16_seq. Lane 0 runs SKIP_ZERO=0 and lane 1 runs SKIP_ZERO=1.
// A per-cycle queue model is compared against directed vectors with literal expectations.
module tb_wallace_mul16_seq;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [7:0]  ma;
    logic [7:0]  mb;
    logic [31:0] prod;
  } cyc_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [2];
  logic [15:0] opa_v   [2];
  logic [15:0] opb_v   [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [31:0] res_v   [2];
  logic [7:0]  ma_v    [2];
  logic [7:0]  mb_v    [2];
  logic [15:0] mp_v    [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] seen[$];
  int          busy_cycles;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    cyc_t        q[$];
    logic [31:0] res_exp = 32'h0;

    wallace_mul16_seq #(.SKIP_ZERO(g == 1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_v[g]),
      .op_a   (opa_v[g]),
      .op_b   (opb_v[g]),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .result (res_v[g]),
      .mul_a  (ma_v[g]),
      .mul_b  (mb_v[g]),
      .mul_p  (mp_v[g])
    );

    // External 8x8 multiplier: combinational, same cycle.
    assign mp_v[g] = 16'(ma_v[g]) * 16'(mb_v[g]);

    // Model: on accept, queue one entry per expected cycle (active PPs, then DONE).
    always @(posedge clk or negedge rst_n) begin : model
      cyc_t       c;
      logic [7:0] ai;
      logic [7:0] bi;
      logic       can_accept;
      if (!rst_n) begin
        q.delete();
        res_exp = 32'h0;
      end else begin
        can_accept = (q.size() == 0) || q[0].done;
        if (q.size() != 0) void'(q.pop_front());
        if (start_v[g] && can_accept) begin
          for (int i = 0; i < 4; i++) begin
            ai = (i % 2 == 1) ? opa_v[g][15:8] : opa_v[g][7:0];
            bi = (i >= 2)     ? opb_v[g][15:8] : opb_v[g][7:0];
            if (g == 0 || (16'(ai) * 16'(bi)) != 16'd0) begin
              c = '0;
              c.busy = 1'b1;
              c.ma = ai;
              c.mb = bi;
              q.push_back(c);
            end
          end
          c = '0;
          c.done = 1'b1;
          c.prod = 32'(opa_v[g]) * 32'(opb_v[g]);
          q.push_back(c);
        end
        if (q.size() != 0 && q[0].done) res_exp = q[0].prod;
      end
    end

    always @(negedge clk) begin : cmp
      cyc_t e;
      if (rst_n) begin
        if (q.size() != 0) e = q[0];
        else e = '0;
        check($sformatf("lane%0d busy", g),   32'(busy_v[g]), 32'(e.busy));
        check($sformatf("lane%0d done", g),   32'(done_v[g]), 32'(e.done));
        check($sformatf("lane%0d mul_a", g),  32'(ma_v[g]),   32'(e.ma));
        check($sformatf("lane%0d mul_b", g),  32'(mb_v[g]),   32'(e.mb));
        check($sformatf("lane%0d result", g), res_v[g],       res_exp);
      end
    end
  end

  // Single start pulse. Latency counts edges from the drive point to the first cycle with done high.
  task automatic do_op(input int lane, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_res, input int exp_edges, input logic [31:0] prev_res);
    int edges;
    seen.delete();
    busy_cycles = 0;
    @(negedge clk);
    start_v[lane] = 1'b1;
    opa_v[lane]   = a;
    opb_v[lane]   = b;
    @(negedge clk);
    start_v[lane] = 1'b0;
    opa_v[lane]   = 16'hDEAD;
    opb_v[lane]   = 16'hBEEF;
    edges = 1;
    while (!done_v[lane] && edges < 20) begin
      if (busy_v[lane]) begin
        seen.push_back({ma_v[lane], mb_v[lane]});
        busy_cycles++;
      end
      check("result held while busy", res_v[lane], prev_res);
      @(negedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(exp_edges));
    check("result", res_v[lane], exp_res);
  endtask

  task automatic count_dones(input int lane, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_v[lane]) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;
    int cnt;
    for (int l = 0; l < 2; l++) begin
      start_v[l] = 1'b0;
      opa_v[l]   = 16'h0;
      opb_v[l]   = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check("reset busy",   32'(busy_v[l]), 32'h0);
      check("reset done",   32'(done_v[l]), 32'h0);
      check("reset result", res_v[l],       32'h0);
    end
    rst_n = 1'b1;

    // SKIP_ZERO=0: all four partial products, literal byte-pair sequence.
    do_op(0, 16'h1234, 16'h5678, 32'h0626_0060, 5, 32'h0);
    check("pp count 1234x5678", 32'(busy_cycles), 32'd4);
    check("pp0 pair", 32'(seen[0]), 32'h3478);
    check("pp1 pair", 32'(seen[1]), 32'h1278);
    check("pp2 pair", 32'(seen[2]), 32'h3456);
    check("pp3 pair", 32'(seen[3]), 32'h1256);
    do_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5, 32'h0626_0060);
    do_op(0, 16'h0000, 16'hABCD, 32'h0000_0000, 5, 32'hFFFE_0001);

    // A start pulse during PP1 is ignored.
    @(negedge clk);
    start_v[0] = 1'b1; opa_v[0] = 16'h1234; opb_v[0] = 16'h5678;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1; opa_v[0] = 16'h1111; opb_v[0] = 16'h1111;
    @(negedge clk);
    start_v[0] = 1'b0;
    edges = 3;
    while (!done_v[0] && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("ignored start latency", 32'(edges), 32'd5);
    check("ignored start result", res_v[0], 32'h0626_0060);
    count_dones(0, 6, cnt);
    check("no extra done", 32'(cnt), 32'd0);

    // start held high: back-to-back with no IDLE bubble.
    @(negedge clk);
    start_v[0] = 1'b1; opa_v[0] = 16'd3; opb_v[0] = 16'd4;
    edges = 0;
    do begin @(negedge clk); edges++; end while (!done_v[0] && edges < 20);
    check("b2b first latency", 32'(edges), 32'd5);
    check("b2b first result", res_v[0], 32'h0000_000C);
    opa_v[0] = 16'h0100; opb_v[0] = 16'h0100;
    edges = 0;
    do begin @(negedge clk); edges++; end while (!done_v[0] && edges < 20);
    check("b2b second latency", 32'(edges), 32'd5);
    check("b2b second result", res_v[0], 32'h0001_0000);
    start_v[0] = 1'b0;

    // SKIP_ZERO=1: only nonzero byte pairs run.
    do_op(1, 16'h0012, 16'h0034, 32'h0000_03A8, 2, 32'h0);
    check("skip pp count", 32'(busy_cycles), 32'd1);
    check("skip pp0 pair", 32'(seen[0]), 32'h1234);
    do_op(1, 16'h0000, 16'h0005, 32'h0000_0000, 1, 32'h0000_03A8);
    do_op(1, 16'h0100, 16'h0001, 32'h0000_0100, 2, 32'h0);
    check("skip pp1 pair", 32'(seen[0]), 32'h0101);
    do_op(1, 16'h1234, 16'h5678, 32'h0626_0060, 5, 32'h0000_0100);

    // Asynchronous reset in PP2 aborts the operation.
    @(negedge clk);
    start_v[0] = 1'b1; opa_v[0] = 16'h1234; opb_v[0] = 16'h5678;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("busy before reset", 32'(busy_v[0]), 32'h1);
    check("mul_a in pp2", 32'(ma_v[0]), 32'h34);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy",   32'(busy_v[0]), 32'h0);
    check("async reset done",   32'(done_v[0]), 32'h0);
    check("async reset result", res_v[0],       32'h0);
    check("async reset lane1 result", res_v[1], 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    count_dones(0, 10, cnt);
    check("no done after abort", 32'(cnt), 32'd0);
    do_op(0, 16'h00FF, 16'h0101, 32'h0000_FFFF, 5, 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
